// File: rtl/csa_seq_pkg.sv
// Shared constants and FSM encoding for the carry-save sequential multiplier.
package csa_seq_pkg;
  localparam int WIDTH = 16;
  localparam int CSA_W = 2 * WIDTH + 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2
  } state_t;
endpackage

// File: rtl/csa_seq_mult_csa.sv
// 3:2 carry-save adder; cout is the carry vector already shifted left by one.
module csa_seq_mult_csa #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W:0]   cout
);
  assign sum  = x ^ y ^ z;
  assign cout = {(x & y) | (x & z) | (y & z), 1'b0};
endmodule

// File: rtl/csa_seq_mult.sv
// Sequential unsigned multiplier: 16 carry-save accumulate cycles followed by
// a single carry-propagate resolve; fixed 17-edge latency.
module csa_seq_mult
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = 16  // datapath is sized for 16 only
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  state_t               state, state_nxt;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [CSA_W-1:0]     sum_r, carry_r, pp, csa_sum;
  logic [CSA_W:0]       csa_cout;
  logic [CNT_W-1:0]     cnt;
  logic                 accept, accum, resolve;
  logic                 csa_cout_unused;
  logic                 resolve_unused;
  logic [2*WIDTH-1:0]   resolve_lo;

  csa_seq_mult_csa #(.W(CSA_W)) u_csa (
    .x    (sum_r),
    .y    (carry_r),
    .z    (pp),
    .sum  (csa_sum),
    .cout (csa_cout)
  );

  // Top carry bit can never be set since a*b < 2^32.
  assign csa_cout_unused = csa_cout[CSA_W];

  always_comb begin
    pp = '0;
    if (b_r[cnt]) pp = {{(CSA_W-WIDTH){1'b0}}, a_r} << cnt;
  end

  assign {resolve_unused, resolve_lo} = sum_r + carry_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (cnt == CNT_W'(15)) state_nxt = RESOLVE;
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state == IDLE) && start;
    accum   = (state == ACCUM);
    resolve = (state == RESOLVE);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= resolve;
      if (accept) begin
        a_r     <= a;
        b_r     <= b;
        sum_r   <= '0;
        carry_r <= '0;
        cnt     <= '0;
      end else if (accum) begin
        sum_r   <= csa_sum;
        carry_r <= csa_cout[CSA_W-1:0];
        cnt     <= cnt + 1'b1;
      end
      if (resolve) product <= resolve_lo;
    end
  end
endmodule
